mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM-stage load/store unit for the 5-stage pipeline CPU; it is the consumer of the decode-stage memory controls DMWe, DMsign, DMwidth, DWea and RFWsrc.
- Drives a req/ack data-memory port, lane-aligns store data and extracts and extends load data.
- Produces the registered mem_RFWe / mem_rfwaddr / mem_rfwdata writeback and forwarding outputs.
- Raises mem_stall while an access is outstanding.

Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for dm_ack before bus error (>=2).
- CNT_W, 5: timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM register holds a valid instruction
- in_aluout  in  32  ALU result / effective address
- in_wdata  in  32  store data (rs2)
- in_pc  in  32  link value for RFW_FROM_PC
- in_DMWe  in  1  store
- in_DMsign  in  1  load sign-extend
- in_DMwidth  in  2  DM_BYTE/DM_HALFWORD/DM_WORD
- in_DWea  in  4  unshifted byte enables from decode
- in_RFWe  in  1  register write enable
- in_RFWsrc  in  2  RFW_FROM_ALU/MEM/PC
- in_rfwaddr  in  5  rd
- dm_req  out  1  memory request, held until ack
- dm_we  out  1  write request
- dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dm_be  out  4  in_DWea shifted left by addr[1:0]
- dm_wdata  out  32  in_wdata shifted left by 8*addr[1:0]
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  access complete
- mem_stall  out  1  hold PC/IF/ID/EX and EX/MEM
- mem_RFWe  out  1  writeback enable; also feeds decode forwarding
- mem_rfwaddr  out  5  writeback rd
- mem_rfwdata  out  32  writeback data
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all outputs 0. Reset mid-access drops dm_req immediately; a later dm_ack is ignored.
- is_mem = in_valid & (in_DMWe | in_RFWsrc==RFW_FROM_MEM).
- FSM IDLE:
  - If in_valid & !is_mem: register the writeback next edge (ALU → in_aluout, PC → in_pc); mem_RFWe = in_RFWe & (rfwaddr!=0); 1-cycle latency, no stall.
  - If is_mem: latch addr/wdata/be/width/sign/rd and go to BUSY; mem_RFWe=0 that cycle.
  - If !in_valid: mem_RFWe=0.
- FSM BUSY:
  - dm_req=1 from latched values (registered, stable until ack); counter increments.
  - dm_ack → DONE. An ack in the first BUSY cycle is legal.
  - counter==TIMEOUT-1 without ack → bus_err pulse, dm_req drops, go to DONE with mem_RFWe=0.
- FSM DONE (1 cycle):
  - Writeback registers are loaded at the DONE entry edge.
  - Load data = dm_rdata >> 8*addr[1:0], then for byte/half: zero- or sign-extend per DMsign; word takes all 32 bits.
  - mem_RFWe = load & rd!=0 & !timeout. Stores write nothing.
  - Next state IDLE. The same instruction is not re-accepted because EX/MEM advances that edge.
- mem_stall = (IDLE & is_mem) | BUSY. It is low in DONE.
- dm_ack outside BUSY is ignored.
- Word access with addr[1:0]!=0, or half with addr[0]=1, is not aligned; the base build still issues it with shifted strobes truncated to 4 bits.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access in IDLE does not enter BUSY and never asserts dm_req.
  - It goes straight to DONE with mem_RFWe=0 and pulses bus_err.
- Undefined: behaviour as in Behaviour above; no alignment check logic is built.

Decomposition:
- ctrl_encode_def.vh supplies DM_BYTE/DM_HALFWORD/DM_WORD and RFW_FROM_ALU/MEM/PC, ENABLE/DISABLE and DATA_INITIAL.
- Add the FSM state encodings LSU_IDLE/LSU_BUSY/LSU_DONE to the same header.
- One sub-module, lsu_load_fmt: combinational shift plus sign/zero-extend of read data from width, sign and addr[1:0]. It is reused by any future cache.

Test Plan:
- ALU op, rd=5, aluout=0x1234 → next cycle mem_RFWe=1, mem_rfwaddr=5, mem_rfwdata=0x1234; mem_stall never high.
- LB signed at addr 0x103; ack after 3 cycles with rdata=0x80FF_0000:
  - mem_stall high 4 cycles.
  - dm_addr=0x100, dm_be=0, dm_we=0.
  - mem_rfwdata=0xFFFF_FF80.
- SH at 0x202, wdata=0x0000_BEEF, DWea=0011 → dm_be=1100, dm_wdata=0xBEEF_0000, dm_we=1; mem_RFWe=0.
- LW with ack never asserted, TIMEOUT=16 → dm_req high 16 cycles; bus_err pulses once; mem_RFWe=0; back to IDLE.
- rst_n low while in BUSY → dm_req=0 immediately; a subsequent dm_ack is ignored; outputs stay 0.
- With MISALIGN_TRAP_EN, LW at 0x101 → dm_req stays 0; bus_err pulses; mem_stall high exactly 1 cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared encodings for the MEM-stage load/store unit
package mem_lsu_pkg;
  localparam logic [1:0] DM_BYTE = 2'b00, DM_HALFWORD = 2'b01, DM_WORD = 2'b10;
  localparam logic [1:0] RFW_FROM_ALU = 2'b00, RFW_FROM_MEM = 2'b01, RFW_FROM_PC = 2'b10;
  localparam logic ENABLE = 1'b1, DISABLE = 1'b0;
  localparam logic [31:0] DATA_INITIAL = 32'h0000_0000;
  typedef enum logic [1:0] {LSU_IDLE = 2'b00, LSU_BUSY = 2'b01, LSU_DONE = 2'b10} lsu_state_e;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data-memory port; master = LSU, slave = memory
//   req/we/addr/be/wdata driven by master, rdata/ack driven by slave
interface mem_lsu_if;
  logic req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  modport master(output req, we, addr, be, wdata, input rdata, ack);
  modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_load_fmt.sv
// lsu_load_fmt: lane-extracts read data by off, then zero/sign-extends byte/half
//   rdata: raw memory word, width/sign: access type, off: addr[1:0], data: result
module lsu_load_fmt
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    data = width == DM_BYTE ? {{24{sign & sh[7]}}, sh[7:0]} :
           width == DM_HALFWORD ? {{16{sign & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with req/ack memory port and registered writeback
//   clk, rst_n (async active-low); in_*: EX/MEM register fields
//   dm: mem_lsu_if master port; mem_stall: pipeline hold
//   mem_RFWe/mem_rfwaddr/mem_rfwdata: writeback/forwarding; bus_err: timeout/trap pulse
//   MISALIGN_TRAP_EN: when defined, misaligned accesses trap instead of being issued
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_aluout,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_pc,
  input  logic        in_DMWe,
  input  logic        in_DMsign,
  input  logic [1:0]  in_DMwidth,
  input  logic [3:0]  in_DWea,
  input  logic        in_RFWe,
  input  logic [1:0]  in_RFWsrc,
  input  logic [4:0]  in_rfwaddr,
  mem_lsu_if.master   dm,
  output logic        mem_stall,
  output logic        mem_RFWe,
  output logic [4:0]  mem_rfwaddr,
  output logic [31:0] mem_rfwdata,
  output logic        bus_err
);
  lsu_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [1:0] width, off;
  logic sign, ld;
  logic [4:0] rd;
  logic [31:0] ld_data;
  logic is_mem, mis;
  assign is_mem = in_valid & (in_DMWe | in_RFWsrc == RFW_FROM_MEM);
`ifdef MISALIGN_TRAP_EN
  assign mis = (in_DMwidth == DM_WORD & |in_aluout[1:0]) | (in_DMwidth == DM_HALFWORD & in_aluout[0]);
`else
  assign mis = DISABLE;
`endif
  assign mem_stall = (state == LSU_IDLE & is_mem) | state == LSU_BUSY;
  lsu_load_fmt u_fmt (.rdata(dm.rdata), .width(width), .sign(sign), .off(off), .data(ld_data));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LSU_IDLE;
      cnt <= '0;
      dm.req <= DISABLE;
      dm.we <= DISABLE;
      dm.addr <= DATA_INITIAL;
      dm.be <= '0;
      dm.wdata <= DATA_INITIAL;
      width <= DM_BYTE;
      sign <= 1'b0;
      off <= '0;
      ld <= 1'b0;
      rd <= '0;
      mem_RFWe <= DISABLE;
      mem_rfwaddr <= '0;
      mem_rfwdata <= DATA_INITIAL;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      mem_RFWe <= DISABLE;
      case (state)
        LSU_IDLE: begin
          cnt <= '0;
          if (is_mem) begin
            // a trapped access skips BUSY so the bus never sees it
            state <= mis ? LSU_DONE : LSU_BUSY;
            dm.req <= !mis;
            bus_err <= mis;
            dm.we <= in_DMWe;
            dm.addr <= {in_aluout[31:2], 2'b00};
            dm.be <= 4'(in_DWea << in_aluout[1:0]);
            dm.wdata <= in_wdata << {in_aluout[1:0], 3'b000};
            width <= in_DMwidth;
            sign <= in_DMsign;
            off <= in_aluout[1:0];
            ld <= !in_DMWe & in_RFWe;
            rd <= in_rfwaddr;
          end else if (in_valid) begin
            mem_RFWe <= in_RFWe & |in_rfwaddr;
            mem_rfwaddr <= in_rfwaddr;
            mem_rfwdata <= in_RFWsrc == RFW_FROM_PC ? in_pc : in_aluout;
          end
        end
        LSU_BUSY: begin
          cnt <= cnt + 1'b1;
          if (dm.ack) begin
            state <= LSU_DONE;
            dm.req <= DISABLE;
            mem_RFWe <= ld & |rd;
            mem_rfwaddr <= rd;
            mem_rfwdata <= ld_data;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= LSU_DONE;
            dm.req <= DISABLE;
            bus_err <= 1'b1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a delayed-ack memory responder
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_DMWe = 0, in_DMsign = 0, in_RFWe = 0;
  logic [31:0] in_aluout = 0, in_wdata = 0, in_pc = 0;
  logic [1:0] in_DMwidth = 0, in_RFWsrc = 0;
  logic [3:0] in_DWea = 0;
  logic [4:0] in_rfwaddr = 0;
  logic mem_stall, mem_RFWe, bus_err;
  logic [4:0] mem_rfwaddr;
  logic [31:0] mem_rfwdata;
  int checks = 0, failures = 0;
  int ack_after = 0, req_cyc = 0;
  logic force_ack = 0;
  logic [31:0] rd_val = 0;
  logic [36:0] sb[$];
  int stalls, reqs, errs;
  logic cap_we;
  logic [3:0] cap_be;
  logic [31:0] cap_addr, cap_wdata;
  typedef struct {
    logic sgn;
    logic [1:0] wid;
    logic [31:0] addr;
    logic [31:0] rdata;
    int ack;
    logic [4:0] rd;
    logic [31:0] exp;
  } ld_t;
  ld_t lds[7];

  mem_lsu_if dm();

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_aluout(in_aluout), .in_wdata(in_wdata),
    .in_pc(in_pc), .in_DMWe(in_DMWe), .in_DMsign(in_DMsign), .in_DMwidth(in_DMwidth),
    .in_DWea(in_DWea), .in_RFWe(in_RFWe), .in_RFWsrc(in_RFWsrc), .in_rfwaddr(in_rfwaddr),
    .dm(dm), .mem_stall(mem_stall), .mem_RFWe(mem_RFWe), .mem_rfwaddr(mem_rfwaddr),
    .mem_rfwdata(mem_rfwdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign dm.rdata = rd_val;
  assign dm.ack = force_ack | (dm.req && req_cyc == ack_after);
  always @(posedge clk) req_cyc <= dm.req ? req_cyc + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mem_RFWe) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        check("wb_rd", 32'(mem_rfwaddr), 32'(e[36:32]));
        check("wb_data", mem_rfwdata, e[31:0]);
      end
    end

  task automatic exec(input logic we, input logic sgn, input logic [1:0] wid, input logic [1:0] src,
                      input logic [3:0] wea, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd);
    in_valid = 1; in_DMWe = we; in_DMsign = sgn; in_DMwidth = wid; in_RFWsrc = src;
    in_DWea = wea; in_aluout = addr; in_wdata = wd; in_pc = addr + 32'h1000;
    in_RFWe = ~we; in_rfwaddr = rd;
    stalls = 0; reqs = 0; errs = 0;
    cap_we = 0; cap_be = 0; cap_addr = 0; cap_wdata = 0;
    #1;
    for (int i = 0; i < 64 && mem_stall; i++) begin
      stalls++;
      if (dm.req) begin
        reqs++;
        cap_we = dm.we; cap_be = dm.be; cap_addr = dm.addr; cap_wdata = dm.wdata;
      end
      @(posedge clk); #1;
      if (bus_err) errs++;
    end
    check("stall_bound", 32'(mem_stall), 0);
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    check("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    lds = '{
      '{1'b1, DM_BYTE,     32'h103, 32'h80FF_0000, 2, 5'd7,  32'hFFFF_FF80},
      '{1'b0, DM_BYTE,     32'h103, 32'h80FF_0000, 0, 5'd8,  32'h0000_0080},
      '{1'b1, DM_BYTE,     32'h101, 32'h0000_7F00, 1, 5'd9,  32'h0000_007F},
      '{1'b1, DM_HALFWORD, 32'h102, 32'h8001_0000, 3, 5'd10, 32'hFFFF_8001},
      '{1'b0, DM_HALFWORD, 32'h100, 32'h1234_F00D, 0, 5'd11, 32'h0000_F00D},
      '{1'b0, DM_WORD,     32'h204, 32'hDEAD_BEEF, 0, 5'd12, 32'hDEAD_BEEF},
      '{1'b1, DM_WORD,     32'h208, 32'h5555_AAAA, 1, 5'd0,  32'h0}
    };
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dm.req), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_we", 32'(mem_RFWe), 0);
    check("rst_data", mem_rfwdata, 0);
    check("rst_err", 32'(bus_err), 0);
    rst_n = 1;
    @(posedge clk); #1;
    sb.push_back({5'd5, 32'h0000_1234});
    exec(0, 0, DM_WORD, RFW_FROM_ALU, 4'h0, 32'h1234, 0, 5'd5);
    check("alu_stall", stalls, 0);
    sb.push_back({5'd1, 32'h0000_1400});
    exec(0, 0, DM_WORD, RFW_FROM_PC, 4'h0, 32'h400, 0, 5'd1);
    check("pc_stall", stalls, 0);
    exec(0, 0, DM_WORD, RFW_FROM_ALU, 4'h0, 32'h55, 0, 5'd0);
    foreach (lds[k]) begin
      ack_after = lds[k].ack;
      rd_val = lds[k].rdata;
      if (lds[k].rd != 0) sb.push_back({lds[k].rd, lds[k].exp});
      exec(0, lds[k].sgn, lds[k].wid, RFW_FROM_MEM, 4'h0, lds[k].addr, 0, lds[k].rd);
      check("ld_stall", stalls, lds[k].ack + 2);
      check("ld_reqs", reqs, lds[k].ack + 1);
      check("ld_addr", cap_addr, {lds[k].addr[31:2], 2'b00});
      check("ld_be", 32'(cap_be), 0);
      check("ld_we", 32'(cap_we), 0);
      check("ld_err", errs, 0);
    end
    ack_after = 1;
    exec(1, 0, DM_HALFWORD, RFW_FROM_ALU, 4'b0011, 32'h202, 32'h0000_BEEF, 5'd3);
    check("sh_be", 32'(cap_be), 32'b1100);
    check("sh_wdata", cap_wdata, 32'hBEEF_0000);
    check("sh_we", 32'(cap_we), 1);
    check("sh_addr", cap_addr, 32'h200);
    exec(1, 0, DM_BYTE, RFW_FROM_ALU, 4'b0001, 32'h301, 32'h0000_00A5, 5'd3);
    check("sb_be", 32'(cap_be), 32'b0010);
    check("sb_wdata", cap_wdata, 32'h0000_A500);
    exec(1, 0, DM_WORD, RFW_FROM_ALU, 4'b1111, 32'h40, 32'h1122_3344, 5'd3);
    check("sw_be", 32'(cap_be), 32'b1111);
    check("sw_wdata", cap_wdata, 32'h1122_3344);
    ack_after = 1000;
    exec(0, 0, DM_WORD, RFW_FROM_MEM, 4'h0, 32'h500, 0, 5'd13);
    check("to_reqs", reqs, 16);
    check("to_stall", stalls, 17);
    check("to_err", errs, 1);
    check("to_err_low", 32'(bus_err), 0);
    check("to_idle", 32'(mem_stall), 0);
    ack_after = 0;
    rd_val = 32'hAABB_CCDD;
`ifdef MISALIGN_TRAP_EN
    exec(0, 0, DM_WORD, RFW_FROM_MEM, 4'h0, 32'h101, 0, 5'd15);
    check("mis_reqs", reqs, 0);
    check("mis_stall", stalls, 1);
    check("mis_err", errs, 1);
`else
    sb.push_back({5'd15, 32'h00AA_BBCC});
    exec(0, 0, DM_WORD, RFW_FROM_MEM, 4'h0, 32'h101, 0, 5'd15);
    check("mis_reqs", reqs, 1);
    check("mis_stall", stalls, 2);
    check("mis_addr", cap_addr, 32'h100);
    check("mis_err", errs, 0);
`endif
    ack_after = 1000;
    in_valid = 1; in_DMWe = 0; in_DMsign = 0; in_DMwidth = DM_WORD; in_RFWsrc = RFW_FROM_MEM;
    in_DWea = 0; in_aluout = 32'h600; in_RFWe = 1; in_rfwaddr = 5'd14;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_req_pre", 32'(dm.req), 1);
    in_valid = 0;
    rst_n = 0;
    #1;
    check("rst_mid_req", 32'(dm.req), 0);
    check("rst_mid_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    rst_n = 1;
    force_ack = 1;
    @(posedge clk); #1;
    force_ack = 0;
    check("rst_ack_we", 32'(mem_RFWe), 0);
    check("rst_ack_err", 32'(bus_err), 0);
    check("rst_ack_data", mem_rfwdata, 0);
    check("rst_ack_req", 32'(dm.req), 0);
    @(posedge clk); #1;
    check("rst_ack_we2", 32'(mem_RFWe), 0);
    ack_after = 0;
    sb.push_back({5'd6, 32'h0000_BEEF});
    exec(0, 0, DM_WORD, RFW_FROM_ALU, 4'h0, 32'hBEEF, 0, 5'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
